// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 instruction codes, status codes and memory-stage states
package y86_pkg;

    // Instruction codes (icode field)
    localparam logic [3:0] HALT  = 4'h0;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] CMOV  = 4'h2;
    localparam logic [3:0] IRMOV = 4'h3;
    localparam logic [3:0] RMMOV = 4'h4;
    localparam logic [3:0] MRMOV = 4'h5;
    localparam logic [3:0] OPQ   = 4'h6;
    localparam logic [3:0] JXX   = 4'h7;
    localparam logic [3:0] CALL  = 4'h8;
    localparam logic [3:0] RET   = 4'h9;
    localparam logic [3:0] PUSH  = 4'hA;
    localparam logic [3:0] POP   = 4'hB;

    // Machine status codes
    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    // Memory-stage FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - request/response bundle between sequencer and memory stage
// Ports: start/icode/valE/valA/valP driven by the sequencer (master);
//        busy/done/valM/stat driven by the memory stage (slave).
interface memory_stage_if;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        busy;
    logic        done;
    logic [63:0] valM;
    logic [2:0]  stat;

    modport master (
        output start, icode, valE, valA, valP,
        input  busy, done, valM, stat
    );

    modport slave (
        input  start, icode, valE, valA, valP,
        output busy, done, valM, stat
    );
endinterface

// File: rtl/dmem_bytes.sv
// rtl/dmem_bytes.sv - byte-wide data memory, combinational read, synchronous write
// Ports: clk; we/addr/wdata write port (rising edge); rdata = mem[addr] combinationally.
// The array has no reset: contents survive a stage reset.
module dmem_bytes #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [0:MEM_BYTES-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 SEQ memory stage with byte-serial data memory
// Ports: clk, rst_n (async, active low); bus (slave): start/icode/valE/valA/valP in,
//        busy/done/valM/stat out. Each 8-byte access takes 8 byte cycles, then FIN.
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    memory_stage_if.slave bus
);
    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_r;
    logic [63:0]       data_r;
    logic [63:0]       valm_r;
    logic [2:0]        stat_r;

    // Request decode, evaluated against the live inputs in IDLE
    logic        acc_rd;
    logic        acc_wr;
    logic [63:0] acc_addr;
    logic [63:0] acc_data;
    logic [64:0] acc_last;
    logic        range_bad;

    always_comb begin
        acc_rd   = 1'b0;
        acc_wr   = 1'b0;
        acc_addr = bus.valE;
        acc_data = bus.valA;
        case (bus.icode)
            RMMOV, PUSH: acc_wr = 1'b1;
            CALL: begin
                acc_wr   = 1'b1;
                acc_data = bus.valP;
            end
            MRMOV: acc_rd = 1'b1;
            RET, POP: begin
                acc_rd   = 1'b1;
                acc_addr = bus.valA;
            end
            default: ;
        endcase
    end

    // Last byte address at 65 bits so an address near 2^64 cannot wrap into range
    assign acc_last  = {1'b0, acc_addr} + 65'd7;
    assign range_bad = (acc_last >= 65'(MEM_BYTES));

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    // Range check at accept guarantees addr_r + cnt never wraps
    assign mem_addr  = addr_r + ADDR_W'(cnt);
    assign mem_we    = (state == ST_WR);
    assign mem_wdata = data_r[{cnt, 3'b000} +: 8];

    dmem_bytes #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= 3'd0;
            addr_r <= '0;
            data_r <= '0;
            valm_r <= '0;
            stat_r <= AOK;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A non-AOK status is sticky; requests are dropped until reset
                    if (bus.start && stat_r == AOK) begin
                        cnt    <= 3'd0;
                        addr_r <= acc_addr[ADDR_W-1:0];
                        data_r <= acc_data;
                        if (acc_rd || acc_wr) begin
                            if (range_bad) begin
                                state  <= ST_FIN;
                                stat_r <= ADR;
                                valm_r <= '0;
                            end else if (acc_rd) begin
                                state  <= ST_RD;
                                valm_r <= '0;
                            end else begin
                                state <= ST_WR;
                            end
                        end else begin
                            state <= ST_FIN;
                            if (bus.icode == HALT) begin
                                stat_r <= HLT;
                            end else if (bus.icode >= 4'hC) begin
                                stat_r <= INS;
                            end
                        end
                    end
                end
                ST_RD: begin
                    valm_r[{cnt, 3'b000} +: 8] <= mem_rdata;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= ST_FIN;
                    end
                end
                ST_WR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= ST_FIN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_FIN);
    assign bus.valM = valm_r;
    assign bus.stat = stat_r;
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;
    import y86_pkg::*;

    localparam int MB = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_stage_if bus();

    memory_stage #(
        .MEM_BYTES(MB),
        .ADDR_W   (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte array with known-flags, sticky status, last valM
    logic [7:0]  mm [MB];
    bit          mv [MB];
    logic [2:0]  mstat;
    logic [63:0] mvalm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                              input logic [63:0] p, output int elat, output bit vm_known);
        logic [63:0] ad;
        logic [63:0] wd;
        bit is_rd;
        bit is_wr;
        elat     = 1;
        vm_known = 1;
        is_rd = (ic == MRMOV || ic == RET || ic == POP);
        is_wr = (ic == RMMOV || ic == PUSH || ic == CALL);
        ad = (ic == RET || ic == POP) ? a : e;
        wd = (ic == CALL) ? p : a;
        if (is_rd || is_wr) begin
            if (ad > 64'(MB - 8)) begin
                mstat = ADR;
                mvalm = 64'd0;
            end else begin
                elat = 9;
                for (int i = 0; i < 8; i++) begin
                    if (is_wr) begin
                        mm[int'(ad) + i] = wd[8*i +: 8];
                        mv[int'(ad) + i] = 1'b1;
                    end else begin
                        if (!mv[int'(ad) + i]) vm_known = 0;
                        mvalm[8*i +: 8] = mm[int'(ad) + i];
                    end
                end
            end
        end else if (ic == HALT) begin
            mstat = HLT;
        end else if (ic >= 4'hC) begin
            mstat = INS;
        end
    endtask

    task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, input int poke, output int lat, output bit bok);
        @(negedge clk);
        bus.icode = ic; bus.valE = e; bus.valA = a; bus.valP = p; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.icode = 4'($urandom);
        bus.valE  = {$urandom, $urandom};
        bus.valA  = {$urandom, $urandom};
        bus.valP  = {$urandom, $urandom};
        lat = 1;
        bok = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy !== 1'b1) bok = 0;
            bus.start = (lat == poke);
            @(negedge clk);
            lat++;
        end
        if (bus.busy !== 1'b1) bok = 0;
        bus.start = 1'b0;
    endtask

    task automatic run(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input int poke);
        int  elat;
        int  lat;
        bit  vmk;
        bit  bok;
        model_step(ic, e, a, p, elat, vmk);
        issue(ic, e, a, p, poke, lat, bok);
        chk($sformatf("latency ic=%0h", ic), 64'(lat), 64'(elat));
        chk($sformatf("busy_during ic=%0h", ic), 64'(bok), 64'd1);
        chk($sformatf("stat ic=%0h", ic), 64'(bus.stat), 64'(mstat));
        if (vmk) chk($sformatf("valM ic=%0h", ic), bus.valM, mvalm);
        @(negedge clk);
        chk($sformatf("done_pulse ic=%0h", ic), {bus.busy, bus.done}, 64'd0);
    endtask

    task automatic ignored(input string tag);
        bit ok;
        @(negedge clk);
        bus.icode = RMMOV; bus.valE = 64'h0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ok = 1;
        repeat (3) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) ok = 0;
            @(negedge clk);
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        mstat = AOK;
        mvalm = 64'd0;
        chk({tag, " reset_busy_done"}, {bus.busy, bus.done}, 64'd0);
        chk({tag, " reset_valM"}, bus.valM, 64'd0);
        chk({tag, " reset_stat"}, 64'(bus.stat), 64'(AOK));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops [11] = '{RMMOV, MRMOV, CALL, RET, PUSH, POP, NOP, CMOV, IRMOV, OPQ, JXX};
        logic [63:0] d;
        logic [3:0]  ic;
        logic [63:0] ad;
        int          r;
        bus.start = 1'b0; bus.icode = 4'h0; bus.valE = '0; bus.valA = '0; bus.valP = '0;
        for (int i = 0; i < MB; i++) begin
            mm[i] = 8'h00;
            mv[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        do_reset("initial");

        // Store then load at 0x100
        run(RMMOV, 64'h100, 64'h1122334455667788, 64'h0, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mem[0x%0h]", 256 + i), 64'(dut.u_mem.mem[256 + i]), 64'(8'h88 - 8'(i * 17)));
        end
        run(MRMOV, 64'h100, 64'h0, 64'h0, 0);
        chk("load_0x100", bus.valM, 64'h1122334455667788);
        repeat (3) begin
            @(negedge clk);
            chk("valM_held", bus.valM, 64'h1122334455667788);
        end

        // Range boundaries
        run(MRMOV, 64'(MB - 7), 64'h0, 64'h0, 0);
        ignored("ignored_after_adr");
        do_reset("after_adr");
        run(RMMOV, 64'(MB - 8), 64'hCAFEF00DDEADBEEF, 64'h0, 0);
        run(MRMOV, 64'(MB - 8), 64'h0, 64'h0, 0);
        run(PUSH, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 64'h0, 0);
        do_reset("after_wrap");

        // call/ret with a stray start during the write phase
        run(CALL, 64'h1F8, 64'h0, 64'h42, 3);
        run(RET, 64'h0, 64'h1F8, 64'h0, 5);
        chk("ret_valM", bus.valM, 64'h42);

        // halt / invalid
        run(HALT, 64'h0, 64'h0, 64'h0, 0);
        ignored("ignored_after_hlt");
        do_reset("after_hlt");
        run(4'hD, 64'h0, 64'h0, 64'h0, 0);
        do_reset("after_ins");

        // Reset in the middle of a push: bytes 0..3 land, 4..7 keep old data
        run(PUSH, 64'h200, 64'hA5A5A5A5A5A5A5A5, 64'h0, 0);
        @(negedge clk);
        bus.icode = PUSH; bus.valE = 64'h200; bus.valA = 64'h0102030405060708; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        d = 64'h0102030405060708;
        for (int i = 0; i < 4; i++) mm[512 + i] = d[8*i +: 8];
        do_reset("mid_push");
        run(MRMOV, 64'h200, 64'h0, 64'h0, 0);
        chk("partial_push", bus.valM, 64'hA5A5A5A505060708);

        // Fill 0..0xFF, then random traffic against the model
        for (int i = 0; i < 32; i++) begin
            run(RMMOV, 64'(i * 8), 64'h0, 64'h0, 0);
        end
        for (int i = 0; i < 32; i++) begin
            run(RMMOV, 64'(i * 8), {$urandom, $urandom}, 64'h0, 0);
        end
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 19));
            ic = ops[$urandom_range(0, 10)];
            ad = 64'($urandom_range(0, 248));
            if (r == 0) ad = 64'(MB - int'($urandom_range(0, 7)));
            if (r == 1) ic = HALT;
            if (r == 2) ic = 4'(12 + $urandom_range(0, 3));
            run(ic, ad, (ic == RET || ic == POP) ? ad : {$urandom, $urandom}, {$urandom, $urandom}, 0);
            if (mstat != AOK) begin
                ignored("ignored_random");
                do_reset("random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 SEQ memory stage, directly downstream of execute.
- Consumes icode, valE, valA and valP for one instruction. Performs the data-memory read or write the instruction needs, then returns valM and a machine status.
- The data memory sits inside the block and is byte-addressed, little-endian, with one byte lane. Each 8-byte access is serialised over 8 cycles by a byte counter.
- start/done handshake toward the sequencing controller.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes. Legal addresses are 0..MEM_BYTES-1.
- ADDR_W, 10: width of the byte index. Must equal clog2(MEM_BYTES).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- icode  in  4  instruction code from execute.
- valE  in  64  execute result; address for rmmovq, mrmovq, call and pushq.
- valA  in  64  store data for rmmovq and pushq; address for ret and popq.
- valP  in  64  return address stored by call.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the instruction completes.
- valM  out  64  read data. Valid from the done cycle, held until the next accepted start.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.

Behaviour:
- Reset (async assert): state=IDLE, busy=0, done=0, valM=0, stat=AOK, byte counter=0.
  - Memory array contents are NOT reset.
  - Reset asserted mid-access aborts the access immediately. Bytes already written stay written.
- States: IDLE, RD, WR, FIN.
- IDLE, start=1 and stat==AOK:
  - Latch icode, the address, and the write data into internal registers.
  - Clear valM to 0 if the op is a read.
  - Decode:
    - rmmovq (4): WR, addr=valE, data=valA.
    - pushq (A): WR, addr=valE, data=valA.
    - call (8): WR, addr=valE, data=valP.
    - mrmovq (5): RD, addr=valE.
    - ret (9): RD, addr=valA.
    - popq (B): RD, addr=valA.
    - halt (0): FIN, stat<=HLT.
    - icode 1, 2, 3, 6, 7: FIN, no access.
    - icode C..F: FIN, stat<=INS.
- Address check, done at accept: compute addr+7 at 65-bit width. If it is >= MEM_BYTES, go to FIN with stat<=ADR; no memory byte is touched and valM=0.
- IDLE with start=1 and stat!=AOK: ignored; no busy, no done. Only reset clears a non-AOK stat.
- start while busy: ignored, no queueing. Latched inputs are unaffected by later input changes.
- RD: each cycle k=0..7, valM[8k+7:8k] <= mem[addr+k]. After k=7, go to FIN.
- WR: each cycle k=0..7, mem[addr+k] <= data[8k+7:8k]. After k=7, go to FIN.
- FIN: done=1 for exactly this cycle, then back to IDLE. busy is high in FIN.
- Latency, with start sampled at edge 0:
  - Non-memory ops: FIN in cycle 1.
  - Memory ops: byte cycles 1..8, FIN/done in cycle 9.
  - A new start is accepted in the cycle after done.
- Back-to-back store then load to the same address returns the new data.
- The counter is 3 bits and wraps 7->0 on the state exit. The address index is addr[ADDR_W-1:0]+k, with no wrap because of the range check.

Decomposition:
- y86_pkg holds:
  - icode constants (HALT, NOP, CMOV, IRMOV, RMMOV, MRMOV, OPQ, JXX, CALL, RET, PUSH, POP);
  - stat codes AOK, HLT, ADR, INS;
  - the memory-stage state enum.
- Sub-module dmem_bytes: a MEM_BYTES x 8 array with a combinational read port, plus a synchronous write port (we, addr, wdata).
- memory_stage holds the FSM, the byte counter, the range check and the valM assembly.

Test Plan:
- Reset, then rmmovq with valE=0x100, valA=0x1122334455667788 -> busy cycles 1..9, done at cycle 9, stat=AOK; bytes 0x100..0x107 = 88,77,...,11.
- Then mrmovq with valE=0x100 -> done at cycle 9, valM=0x1122334455667788, held through 3 idle cycles.
- mrmovq with valE=MEM_BYTES-7 -> done at cycle 1, stat=ADR, valM=0. A following start is ignored: busy stays 0.
- call with valE=0x1F8, valP=0x42, then ret with valA=0x1F8 -> valM=0x42. Apply start during the call's WR phase: no effect.
- icode=0 -> done at cycle 1, stat=HLT. icode=0xD after reset -> stat=INS.
- pushq to 0x200 with rst_n dropped at byte cycle 4 -> outputs reset immediately. After release, a read of 0x200 shows bytes 0..3 (or 0..4 if the edge preceded reset) written and the rest unchanged; stat=AOK.
